// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter
// Memory front-end between NUM_CH requesters and NUM_BANK word-interleaved
// SRAM_wrapper banks. Each bank runs its own round-robin arbiter. Requests
// use a valid/ready handshake, and reads return exactly one cycle after they
// are accepted.
//
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   req_*        per-channel request (valid, ready, byte addr, byte-write mask, wdata)
//   rsp_*        per-channel read response (one-cycle pulse, data zero when idle)
//   bank_*       SRAM_wrapper pins per bank (CS, OE, active-low WEB, A, DI, DO)
//   stall_cnt    per-channel stall counters
//
// Optional build macro MEM_ARB_STATS_EN enables saturating stall counters.
// When it is undefined, stall_cnt is tied to 0.
module mem_bank_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int NUM_BANK = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int BANK_AW  = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              req_valid,
  output logic [NUM_CH-1:0]              req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]       req_addr,
  input  logic [NUM_CH*DATA_W/8-1:0]     req_we,
  input  logic [NUM_CH*DATA_W-1:0]       req_wdata,
  output logic [NUM_CH-1:0]              rsp_valid,
  output logic [NUM_CH*DATA_W-1:0]       rsp_rdata,
  output logic [NUM_BANK-1:0]            bank_cs,
  output logic [NUM_BANK-1:0]            bank_oe,
  output logic [NUM_BANK*DATA_W/8-1:0]   bank_web,
  output logic [NUM_BANK*BANK_AW-1:0]    bank_a,
  output logic [NUM_BANK*DATA_W-1:0]     bank_di,
  input  logic [NUM_BANK*DATA_W-1:0]     bank_do,
  output logic [NUM_CH*32-1:0]           stall_cnt
);

  localparam int BYTES  = DATA_W / 8;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BSEL_W = $clog2(NUM_BANK);
  localparam int BANK_W = (NUM_BANK > 1) ? BSEL_W : 1;

  logic [BANK_W-1:0]  ch_bank  [NUM_CH];
  logic [BANK_AW-1:0] ch_local [NUM_CH];
  logic [NUM_CH-1:0]  ch_rd;
  logic [CH_W-1:0]    rr_ptr   [NUM_BANK];
  logic [CH_W-1:0]    win      [NUM_BANK];
  logic [NUM_BANK-1:0] gnt;
  logic [NUM_CH-1:0]  rsp_vld_p1;
  logic [BANK_W-1:0]  rsp_bank_p1 [NUM_CH];
  int                 idx;

  // Byte-offset bits and address bits above the bank window are ignored.
  logic unused_addr;
  assign unused_addr = ^req_addr;

  // Stage p0: address decode, arbitration and bank drive (combinational)
  for (genvar c = 0; c < NUM_CH; c++) begin : g_dec
    assign ch_bank[c]  = (NUM_BANK > 1) ? req_addr[c*ADDR_W+2 +: BANK_W] : '0;
    assign ch_local[c] = req_addr[c*ADDR_W+2+BSEL_W +: BANK_AW];
    assign ch_rd[c]    = ~|req_we[c*BYTES +: BYTES];
  end

  // Grants are suppressed while reset is asserted, so ready and all bank
  // pins fall idle for the whole reset cycle.
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int b = 0; b < NUM_BANK; b++) begin
      win[b] = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (int'(rr_ptr[b]) + k) % NUM_CH;
        if (rst && !gnt[b] && req_valid[idx] && (int'(ch_bank[idx]) == b)) begin
          gnt[b] = 1'b1;
          win[b] = CH_W'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    bank_cs   = '0;
    bank_oe   = '0;
    bank_web  = '1;
    bank_a    = '0;
    bank_di   = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (gnt[b]) begin
        req_ready[win[b]]          = 1'b1;
        bank_cs[b]                 = 1'b1;
        bank_a[b*BANK_AW +: BANK_AW] = ch_local[win[b]];
        bank_di[b*DATA_W +: DATA_W]  = req_wdata[win[b]*DATA_W +: DATA_W];
        if (ch_rd[win[b]]) begin
          bank_oe[b] = 1'b1;
        end else begin
          bank_web[b*BYTES +: BYTES] = ~req_we[win[b]*BYTES +: BYTES];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (!rst) begin
        rr_ptr[b] <= '0;
      end else if (gnt[b]) begin
        rr_ptr[b] <= (int'(win[b]) == NUM_CH - 1) ? '0 : win[b] + 1'b1;
      end
    end
  end

  // Stage p1: read response, data taken straight from the bank it was issued to
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_vld_p1 <= '0;
      for (int c = 0; c < NUM_CH; c++) rsp_bank_p1[c] <= '0;
    end else begin
      rsp_vld_p1 <= req_ready & ch_rd;
      for (int c = 0; c < NUM_CH; c++) rsp_bank_p1[c] <= ch_bank[c];
    end
  end

  // Gating with rst drops a response whose read was accepted just before reset.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst && rsp_vld_p1[c]) begin
        rsp_valid[c] = 1'b1;
        rsp_rdata[c*DATA_W +: DATA_W] = bank_do[rsp_bank_p1[c]*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stall_q [NUM_CH];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst) begin
        stall_q[c] <= '0;
      end else if (req_valid[c] && !req_ready[c]) begin
        stall_q[c] <= sat_inc(stall_q[c]);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) stall_cnt[c*32 +: 32] = stall_q[c];
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_bank_arbiter.sv
module tb_mem_bank_arbiter;
  localparam int NUM_CH = 2, NUM_BANK = 2, ADDR_W = 32, DATA_W = 32, BANK_AW = 14;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_CH-1:0]            req_valid;
  logic [NUM_CH-1:0]            req_ready;
  logic [NUM_CH*ADDR_W-1:0]     req_addr;
  logic [NUM_CH*DATA_W/8-1:0]   req_we;
  logic [NUM_CH*DATA_W-1:0]     req_wdata;
  logic [NUM_CH-1:0]            rsp_valid;
  logic [NUM_CH*DATA_W-1:0]     rsp_rdata;
  logic [NUM_BANK-1:0]          bank_cs;
  logic [NUM_BANK-1:0]          bank_oe;
  logic [NUM_BANK*DATA_W/8-1:0] bank_web;
  logic [NUM_BANK*BANK_AW-1:0]  bank_a;
  logic [NUM_BANK*DATA_W-1:0]   bank_di;
  logic [NUM_BANK*DATA_W-1:0]   bank_do;
  logic [NUM_CH*32-1:0]         stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  mem_bank_arbiter #(.NUM_CH(NUM_CH), .NUM_BANK(NUM_BANK), .ADDR_W(ADDR_W),
                     .DATA_W(DATA_W), .BANK_AW(BANK_AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bank_cs(bank_cs), .bank_oe(bank_oe), .bank_web(bank_web), .bank_a(bank_a),
    .bank_di(bank_di), .bank_do(bank_do), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // SRAM_wrapper model: synchronous byte-masked write, registered read data.
  logic [31:0] mem [NUM_BANK][1<<BANK_AW];
  initial begin
    bank_do = '0;
    for (int b = 0; b < NUM_BANK; b++)
      for (int w = 0; w < (1<<BANK_AW); w++) mem[b][w] = '0;
  end
  always @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (bank_cs[b]) begin
        for (int i = 0; i < 4; i++)
          if (!bank_web[b*4+i]) mem[b][bank_a[b*BANK_AW +: BANK_AW]][i*8 +: 8] <= bank_di[b*32+i*8 +: 8];
        if (bank_oe[b]) bank_do[b*32 +: 32] <= mem[b][bank_a[b*BANK_AW +: BANK_AW]];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic set_ch(input int c, input logic v, input logic [31:0] addr,
                        input logic [3:0] we, input logic [31:0] wd);
    req_valid[c]           = v;
    req_addr[c*32 +: 32]   = addr;
    req_we[c*4 +: 4]       = we;
    req_wdata[c*32 +: 32]  = wd;
  endtask

  task automatic idle_all();
    set_ch(0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_ch(1, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_ch(0, 1'b1, 32'h0, 4'h0, 32'h0);
    set_ch(1, 1'b1, 32'h4, 4'hF, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready cyc%0d got %b exp 00", i, req_ready); end
      vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid cyc%0d got %b exp 00", i, rsp_valid); end
      vectors++; if (bank_cs !== 2'b00) begin miscompares++; $display("FAIL reset_cs cyc%0d got %b exp 00", i, bank_cs); end
      vectors++; if (bank_web !== 8'hFF) begin miscompares++; $display("FAIL reset_web cyc%0d got %h exp ff", i, bank_web); end
    end
    cyc();
    rst = 1'b1;
    idle_all();
  endtask

  task automatic test_write_read();
    set_ch(0, 1'b1, 32'h0000_0004, 4'hF, 32'hDEAD_BEEF);
    settle();
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL wr_ready got %b exp 01", req_ready); end
    vectors++; if (bank_cs !== 2'b10) begin miscompares++; $display("FAIL wr_cs got %b exp 10", bank_cs); end
    vectors++; if (bank_a[14 +: 14] !== 14'd0) begin miscompares++; $display("FAIL wr_a got %h exp 0", bank_a[14 +: 14]); end
    vectors++; if (bank_web !== 8'h0F) begin miscompares++; $display("FAIL wr_web got %h exp 0f", bank_web); end
    vectors++; if (bank_di[32 +: 32] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_di got %h exp deadbeef", bank_di[32 +: 32]); end
    vectors++; if (bank_oe !== 2'b00) begin miscompares++; $display("FAIL wr_oe got %b exp 00", bank_oe); end
    cyc();
    set_ch(0, 1'b1, 32'h0000_0004, 4'h0, 32'h0);
    settle();
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rd_ready got %b exp 01", req_ready); end
    vectors++; if (bank_oe !== 2'b10) begin miscompares++; $display("FAIL rd_oe got %b exp 10", bank_oe); end
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL wr_no_rsp got %b exp 00", rsp_valid); end
    vectors++; if (rsp_rdata !== 64'h0) begin miscompares++; $display("FAIL rdata_idle_zero got %h exp 0", rsp_rdata); end
    cyc();
    idle_all();
    settle();
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL rd_rsp_valid got %b exp 01", rsp_valid); end
    vectors++; if (rsp_rdata[31:0] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_rdata got %h exp deadbeef", rsp_rdata[31:0]); end
  endtask

  task automatic test_byte_write();
    cyc();
    set_ch(0, 1'b1, 32'h0000_0008, 4'hF, 32'h1122_3344);
    settle();
    vectors++; if (bank_cs !== 2'b01) begin miscompares++; $display("FAIL bw_fill_cs got %b exp 01", bank_cs); end
    vectors++; if (bank_a[0 +: 14] !== 14'd1) begin miscompares++; $display("FAIL bw_fill_a got %h exp 1", bank_a[0 +: 14]); end
    cyc();
    set_ch(0, 1'b1, 32'h0000_0008, 4'b0010, 32'h0000_AA00);
    settle();
    vectors++; if (bank_web[3:0] !== 4'b1101) begin miscompares++; $display("FAIL bw_web got %b exp 1101", bank_web[3:0]); end
    cyc();
    set_ch(0, 1'b1, 32'h0000_0008, 4'h0, 32'h0);
    cyc();
    idle_all();
    settle();
    vectors++; if (rsp_rdata[31:0] !== 32'h1122_AA44) begin miscompares++; $display("FAIL bw_rdata got %h exp 1122aa44", rsp_rdata[31:0]); end
    vectors++; if ({bank_cs, bank_oe, bank_a, bank_di} !== {2'b00, 2'b00, 28'h0, 64'h0}) begin
      miscompares++; $display("FAIL idle_bank got cs=%b oe=%b a=%h di=%h exp all 0", bank_cs, bank_oe, bank_a, bank_di);
    end
  endtask

  task automatic test_parallel();
    cyc();
    set_ch(0, 1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D);
    cyc();
    set_ch(0, 1'b1, 32'h0000_0000, 4'h0, 32'h0);
    set_ch(1, 1'b1, 32'h0000_0004, 4'h0, 32'h0);
    settle();
    vectors++; if (req_ready !== 2'b11) begin miscompares++; $display("FAIL par_ready got %b exp 11", req_ready); end
    vectors++; if (bank_oe !== 2'b11) begin miscompares++; $display("FAIL par_oe got %b exp 11", bank_oe); end
    cyc();
    idle_all();
    settle();
    vectors++; if (rsp_valid !== 2'b11) begin miscompares++; $display("FAIL par_rsp_valid got %b exp 11", rsp_valid); end
    vectors++; if (rsp_rdata !== 64'hDEAD_BEEF_CAFE_F00D) begin miscompares++; $display("FAIL par_rdata got %h exp deadbeefcafef00d", rsp_rdata); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy [4];
    logic [31:0] exp_stall;
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
`ifdef MEM_ARB_STATS_EN
    exp_stall = 32'd2;
`else
    exp_stall = 32'd0;
`endif
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    set_ch(0, 1'b1, 32'h0000_0000, 4'h0, 32'h0);
    set_ch(1, 1'b1, 32'h0000_0008, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      settle();
      vectors++; if (req_ready !== exp_rdy[i]) begin miscompares++; $display("FAIL rr_ready cyc%0d got %b exp %b", i, req_ready, exp_rdy[i]); end
      if (i > 0) begin
        vectors++; if (rsp_valid !== exp_rdy[i-1]) begin miscompares++; $display("FAIL rr_rsp_valid cyc%0d got %b exp %b", i, rsp_valid, exp_rdy[i-1]); end
      end
      if (i == 1) begin
        vectors++; if (rsp_rdata[31:0] !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL rr_rdata0 got %h exp cafef00d", rsp_rdata[31:0]); end
      end
      if (i == 2) begin
        vectors++; if (rsp_rdata[63:32] !== 32'h1122_AA44) begin miscompares++; $display("FAIL rr_rdata1 got %h exp 1122aa44", rsp_rdata[63:32]); end
      end
      cyc();
    end
    idle_all();
    settle();
    vectors++; if (rsp_valid !== 2'b10) begin miscompares++; $display("FAIL rr_last_rsp got %b exp 10", rsp_valid); end
    vectors++; if (stall_cnt[31:0] !== exp_stall) begin miscompares++; $display("FAIL rr_stall0 got %0d exp %0d", stall_cnt[31:0], exp_stall); end
    vectors++; if (stall_cnt[63:32] !== exp_stall) begin miscompares++; $display("FAIL rr_stall1 got %0d exp %0d", stall_cnt[63:32], exp_stall); end
  endtask

  task automatic test_reset_mid();
    cyc();
    set_ch(0, 1'b1, 32'h0000_0004, 4'h0, 32'h0);
    settle();
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rm_ready got %b exp 01", req_ready); end
    cyc();
    rst = 1'b0;
    idle_all();
    settle();
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rm_rsp_n1 got %b exp 00", rsp_valid); end
    vectors++; if (rsp_rdata !== 64'h0) begin miscompares++; $display("FAIL rm_rdata_n1 got %h exp 0", rsp_rdata); end
    cyc();
    rst = 1'b1;
    settle();
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rm_rsp_n2 got %b exp 00", rsp_valid); end
    vectors++; if (stall_cnt !== 64'h0) begin miscompares++; $display("FAIL rm_stall_clr got %h exp 0", stall_cnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_valid = '0; req_addr = '0; req_we = '0; req_wdata = '0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_parallel();
    test_round_robin();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
